pulse_width_meter: RTL and testbench

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

---
 rtl/pulse_width_meter.sv | 186 ++++++++++++++++++
 tb/tb_pulse_width_meter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// Measures high time and period of a pulse train from upstream edge strobes and
// queues {high, period, sat} records in a small FIFO with sticky error/overflow flags.
module pulse_width_meter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     rise_edge,
    input  logic                     fallen_edge,
    input  logic                     clear,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNT_W-1:0]         m_high,
    output logic [CNT_W-1:0]         m_period,
    output logic                     m_sat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     proto_err,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // Reset asserts asynchronously, releases two clk edges later.
    logic rst_meta, rst_n_sync;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_sat, sat_nxt;
    logic [CNT_W-1:0] high_lat, high_nxt;
    logic             push_c, perr_set_c;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state    <= IDLE;
            cnt      <= '0;
            cnt_sat  <= 1'b0;
            high_lat <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cnt_sat  <= sat_nxt;
            high_lat <= high_nxt;
        end
    end

    // cnt holds (current cycle - cycle of the opening rise), saturating.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sat_nxt    = cnt_sat;
        high_nxt   = high_lat;
        push_c     = 1'b0;
        perr_set_c = 1'b0;
        if (state != IDLE) begin
            if (cnt == CNT_MAX) sat_nxt = 1'b1;
            else                cnt_nxt = cnt + CNT_W'(1);
        end
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
        end else if (rise_edge && fallen_edge) begin
            perr_set_c = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_edge) begin
                        state_nxt = HIGH;
                        cnt_nxt   = CNT_W'(1);
                        sat_nxt   = 1'b0;
                    end
                end
                HIGH: begin
                    if (rise_edge) begin
                        perr_set_c = 1'b1;
                        cnt_nxt    = CNT_W'(1);
                        sat_nxt    = 1'b0;
                    end else if (fallen_edge) begin
                        high_nxt  = cnt;
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    if (rise_edge) begin
                        push_c    = 1'b1;
                        state_nxt = HIGH;
                        cnt_nxt   = CNT_W'(1);
                        sat_nxt   = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic [CNT_W-1:0] mem_high   [DEPTH];
    logic [CNT_W-1:0] mem_period [DEPTH];
    logic             mem_sat    [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [LVL_W-1:0] lvl_nxt;
    logic             pop_c, full_c, push_ok_c, drop_c;

    assign pop_c     = m_valid & m_ready;
    assign full_c    = (level == LVL_W'(DEPTH));
    assign push_ok_c = push_c & (~full_c | pop_c);
    assign drop_c    = push_c & full_c & ~pop_c;
    assign rd_nxt    = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        lvl_nxt = level;
        if (push_ok_c && !pop_c)      lvl_nxt = level + LVL_W'(1);
        else if (!push_ok_c && pop_c) lvl_nxt = level - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_high[wr_ptr]   <= high_lat;
            mem_period[wr_ptr] <= cnt;
            mem_sat[wr_ptr]    <= cnt_sat;
        end
    end

    // Head registers are loaded with next cycle's head, bypassing a same-cycle write.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            m_valid  <= 1'b0;
            m_high   <= '0;
            m_period <= '0;
            m_sat    <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr  <= rd_nxt;
            level   <= lvl_nxt;
            m_valid <= (lvl_nxt != '0);
            if (push_ok_c && (wr_ptr == rd_nxt)) begin
                m_high   <= high_lat;
                m_period <= cnt;
                m_sat    <= cnt_sat;
            end else begin
                m_high   <= mem_high[rd_nxt];
                m_period <= mem_period[rd_nxt];
                m_sat    <= mem_sat[rd_nxt];
            end
        end
    end

    // Sticky status: a new error or drop takes priority over clear.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (perr_set_c) proto_err <= 1'b1;
            else if (clear) proto_err <= 1'b0;
            if (drop_c) begin
                overflow <= 1'b1;
                if (clear)                  drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else if (clear) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: directed vector table, hand sequences for
// saturation/overflow/reset, and randomized traffic against a timestamp model.
module tb_pulse_width_meter;

    logic clk, rst, enable, rise_edge, fallen_edge, clear, m_ready;
    logic        m_valid, m_sat, overflow, proto_err;
    logic [15:0] m_high, m_period;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;
    logic        m_valid4, m_sat4, overflow4, proto_err4;
    logic [3:0]  m_high4, m_period4;
    logic [2:0]  level4;
    logic [7:0]  drop_cnt4;

    int n_cmp = 0;
    int n_fail = 0;

    pulse_width_meter #(.CNT_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rise_edge(rise_edge),
        .fallen_edge(fallen_edge), .clear(clear), .m_valid(m_valid),
        .m_ready(m_ready), .m_high(m_high), .m_period(m_period), .m_sat(m_sat),
        .level(level), .overflow(overflow), .proto_err(proto_err),
        .drop_cnt(drop_cnt)
    );

    pulse_width_meter #(.CNT_W(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .rise_edge(rise_edge),
        .fallen_edge(fallen_edge), .clear(clear), .m_valid(m_valid4),
        .m_ready(m_ready), .m_high(m_high4), .m_period(m_period4), .m_sat(m_sat4),
        .level(level4), .overflow(overflow4), .proto_err(proto_err4),
        .drop_cnt(drop_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          gap;
        logic        rise;
        logic        fall;
        logic        clr;
        logic        rdy;
        logic        ev;
        logic [15:0] eh;
        logic [15:0] ep;
        logic [2:0]  el;
        logic        eperr;
    } vec_t;

    typedef struct {
        int h;
        int p;
        bit s;
    } rec_t;

    localparam int NV = 13;
    localparam int MAX16 = 65535;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rise_edge = 1'b0; fallen_edge = 1'b0; clear = 1'b0; enable = 1'b0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
    endtask

    // Rise now, fall h cycles later; the next rise is due p cycles after this one.
    task automatic pulse(input int h, input int p);
        rise_edge = 1'b1; tick(); rise_edge = 1'b0;
        repeat (h - 1) tick();
        fallen_edge = 1'b1; tick(); fallen_edge = 1'b0;
        repeat (p - h - 1) tick();
    endtask

    function automatic int satv(input int v);
        return (v > MAX16) ? MAX16 : v;
    endfunction

    // Reference model state: timestamps of open edges plus a record queue.
    rec_t q[$];
    bit   have_rise, have_fall, m_perr, m_ovf;
    int   tr, tf, t, m_drop;

    initial begin
        vecs[0]  = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b0};
        vecs[1]  = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b0};
        vecs[2]  = '{6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 16'd10, 3'd1, 1'b0};
        vecs[3]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b0};
        vecs[4]  = '{2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b1};
        vecs[5]  = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b1};
        vecs[6]  = '{2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 16'd6,  3'd1, 1'b1};
        vecs[7]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b0};
        vecs[8]  = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b0};
        vecs[9]  = '{1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b1};
        vecs[10] = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd8,  3'd1, 1'b1};
        vecs[11] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd8,  3'd1, 1'b1};
        vecs[12] = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0,  3'd0, 1'b1};

        m_ready = 1'b0;
        rise_edge = 1'b0; fallen_edge = 1'b0; clear = 1'b0; enable = 1'b0;
        rst = 1'b0;
        tick(); tick(); tick();
        check("rst_valid", m_valid, 0);
        check("rst_level", level, 0);
        check("rst_high", m_high, 0);
        check("rst_period", m_period, 0);
        check("rst_sat", m_sat, 0);
        check("rst_ovf", overflow, 0);
        check("rst_perr", proto_err, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b1;
        tick(); tick(); tick();
        enable = 1'b1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            m_ready = vecs[i].rdy;
            repeat (vecs[i].gap) tick();
            rise_edge = vecs[i].rise; fallen_edge = vecs[i].fall; clear = vecs[i].clr;
            tick();
            rise_edge = 1'b0; fallen_edge = 1'b0; clear = 1'b0;
            check($sformatf("vec%0d_valid", i), m_valid, vecs[i].ev);
            check($sformatf("vec%0d_level", i), level, vecs[i].el);
            check($sformatf("vec%0d_perr", i), proto_err, vecs[i].eperr);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_high", i), m_high, vecs[i].eh);
                check($sformatf("vec%0d_period", i), m_period, vecs[i].ep);
                check($sformatf("vec%0d_sat", i), m_sat, 0);
            end
        end

        // Counter saturation on the 4-bit instance
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        pulse(20, 40);
        rise_edge = 1'b1; tick(); rise_edge = 1'b0;
        check("sat4_valid", m_valid4, 1);
        check("sat4_high", m_high4, 15);
        check("sat4_period", m_period4, 15);
        check("sat4_sat", m_sat4, 1);
        check("sat16_high", m_high, 20);
        check("sat16_period", m_period, 40);
        check("sat16_sat", m_sat, 0);

        // Overflow: six records into a four-deep FIFO with no consumer
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        for (int k = 0; k < 6; k++) pulse(k + 2, 10);
        rise_edge = 1'b1; tick(); rise_edge = 1'b0;
        enable = 1'b0; tick();
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_drop", drop_cnt, 2);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_rd%0d_valid", k), m_valid, 1);
            check($sformatf("ovf_rd%0d_high", k), m_high, k + 2);
            check($sformatf("ovf_rd%0d_period", k), m_period, 10);
            tick();
        end
        check("ovf_empty_valid", m_valid, 0);
        check("ovf_empty_level", level, 0);
        check("ovf_sticky", overflow, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_drop", drop_cnt, 0);

        // Asynchronous reset in HIGH with two records queued
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        pulse(3, 7);
        pulse(3, 7);
        rise_edge = 1'b1; tick(); rise_edge = 1'b0;
        check("mrst_pre_level", level, 2);
        rst = 1'b0;
        #2;
        check("mrst_valid", m_valid, 0);
        check("mrst_level", level, 0);
        #1 rst = 1'b1;
        tick(); tick(); tick();
        fallen_edge = 1'b1; tick(); fallen_edge = 1'b0;
        tick(); tick();
        rise_edge = 1'b1; tick(); rise_edge = 1'b0;
        check("mrst_norec", m_valid, 0);
        tick();
        fallen_edge = 1'b1; tick(); fallen_edge = 1'b0;
        tick();
        rise_edge = 1'b1; tick(); rise_edge = 1'b0;
        check("mrst_rec_valid", m_valid, 1);
        check("mrst_rec_high", m_high, 2);
        check("mrst_rec_period", m_period, 4);

        // Randomized traffic against the reference model
        do_reset();
        q.delete();
        have_rise = 0; have_fall = 0; m_perr = 0; m_ovf = 0; m_drop = 0; t = 0;
        tr = 0; tf = 0;
        for (int i = 0; i < 3000; i++) begin
            bit en, r, f, rdy, clr, pop, push, drop, perr_set;
            rec_t nr;
            check("rnd_valid", m_valid, (q.size() != 0));
            check("rnd_level", level, q.size());
            if (q.size() != 0) begin
                check("rnd_high", m_high, q[0].h);
                check("rnd_period", m_period, q[0].p);
                check("rnd_sat", m_sat, q[0].s);
            end
            check("rnd_ovf", overflow, m_ovf);
            check("rnd_perr", proto_err, m_perr);
            check("rnd_drop", drop_cnt, m_drop);

            en  = ($urandom_range(0, 59) != 0);
            r   = ($urandom_range(0, 5) == 0);
            f   = ($urandom_range(0, 4) == 0);
            rdy = (((i / 300) % 2) != 0) ? ($urandom_range(0, 9) == 0)
                                         : ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            enable = en; rise_edge = r; fallen_edge = f; m_ready = rdy; clear = clr;

            pop = (q.size() != 0) && rdy;
            push = 0; drop = 0; perr_set = 0;
            nr = '{0, 0, 0};
            if (!en) begin
                have_rise = 0;
            end else if (r && f) begin
                perr_set = 1;
            end else if (r) begin
                if (have_rise && have_fall) begin
                    push = 1;
                    nr.h = satv(tf - tr);
                    nr.p = satv(t - tr);
                    nr.s = ((t - tr) > MAX16);
                end else if (have_rise) begin
                    perr_set = 1;
                end
                have_rise = 1; have_fall = 0; tr = t;
            end else if (f) begin
                if (have_rise && !have_fall) begin
                    have_fall = 1; tf = t;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < 4) q.push_back(nr);
                else drop = 1;
            end
            if (perr_set) m_perr = 1;
            else if (clr) m_perr = 0;
            if (drop) begin
                m_ovf = 1;
                m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (clr) begin
                m_ovf = 0;
                m_drop = 0;
            end
            t++;
            tick();
        end
        rise_edge = 1'b0; fallen_edge = 1'b0; clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
